spart_word_ctrl: RTL and testbench

//  Sequences 16-bit SPART transfers for the MEM stage. A TX request is split into
//  two byte writes; the controller drives the byte-select of the SPART output mux.
//  An RX request assembles two byte reads into a word.
//  The pipeline is stalled until the transfer completes or a watchdog expires.

---
 rtl/spart_ctrl_pkg.sv | 32 +++
 rtl/spart_word_ctrl_if.sv | 29 ++
 rtl/spart_wdog.sv | 34 +++
 rtl/spart_word_ctrl.sv | 121 ++++++++++++
 tb/tb_spart_word_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_ctrl_pkg.sv
// Shared encodings and widths for the SPART 16-bit word transfer controller.
package spart_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WDOG_W  = 16;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_TX0     = 3'd1;
  localparam logic [STATE_W-1:0] ST_TX0_GAP = 3'd2;
  localparam logic [STATE_W-1:0] ST_TX1     = 3'd3;
  localparam logic [STATE_W-1:0] ST_RX0     = 3'd4;
  localparam logic [STATE_W-1:0] ST_RX0_GAP = 3'd5;
  localparam logic [STATE_W-1:0] ST_RX1     = 3'd6;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_TX0     = ST_TX0,
    S_TX0_GAP = ST_TX0_GAP,
    S_TX1     = ST_TX1,
    S_RX0     = ST_RX0,
    S_RX0_GAP = ST_RX0_GAP,
    S_RX1     = ST_RX1,
    S_DONE    = ST_DONE
  } state_e;

  localparam logic IORW_READ  = 1'b1;
  localparam logic IORW_WRITE = 1'b0;

endpackage

// File: rtl/spart_word_ctrl_if.sv
// MEM-stage / SPART side signals of the word transfer controller.
interface spart_word_ctrl_if;
  import spart_ctrl_pkg::*;

  logic              tx_req;
  logic              rx_req;
  logic [WORD_W-1:0] tx_data;
  logic              tbr;
  logic              rda;
  logic [BYTE_W-1:0] rx_byte;
  logic              stall;
  logic              byte_sel;
  logic              iocs;
  logic              iorw;
  logic [WORD_W-1:0] tx_word;
  logic [WORD_W-1:0] rx_word;
  logic              done;
  logic              err;

  modport master (
    output tx_req, rx_req, tx_data, tbr, rda, rx_byte,
    input  stall, byte_sel, iocs, iorw, tx_word, rx_word, done, err
  );

  modport slave (
    input  tx_req, rx_req, tx_data, tbr, rda, rx_byte,
    output stall, byte_sel, iocs, iorw, tx_word, rx_word, done, err
  );
endinterface

// File: rtl/spart_wdog.sv
// Saturating wait-cycle counter; expired flags the last allowed cycle (limit 0 = never).
module spart_wdog
  import spart_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              expired_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (limit_i != '0) && (cnt_q == (limit_i - WDOG_W'(1)));

endmodule

// File: rtl/spart_word_ctrl.sv
// Splits MEM-stage 16-bit SPART transfers into two byte strobes, stalling the
// pipeline until the word completes or the watchdog aborts it.
module spart_word_ctrl
  import spart_ctrl_pkg::*;
#(
  parameter bit                HI_FIRST = 1'b1,
  parameter logic [WDOG_W-1:0] TIMEOUT  = 16'd0
) (
  input logic               clk,
  input logic               rst_n,
  spart_word_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] tx_word_q, tx_word_d;
  logic [WORD_W-1:0] rx_word_q, rx_word_d;
  logic              err_q, err_d;
  logic              stall_c, iocs_c, iorw_c, byte_sel_c;
  logic              wd_active, wd_expired;

  spart_wdog u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!wd_active),
    .en_i      (wd_active),
    .limit_i   (TIMEOUT),
    .expired_o (wd_expired)
  );

  // Next state, strobes and data capture; strobes are same-cycle with the SPART flags.
  always_comb begin
    state_d    = state_q;
    tx_word_d  = tx_word_q;
    rx_word_d  = rx_word_q;
    err_d      = err_q;
    stall_c    = 1'b0;
    iocs_c     = 1'b0;
    iorw_c     = IORW_WRITE;
    byte_sel_c = HI_FIRST;
    wd_active  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.tx_req || bus.rx_req) begin
          stall_c   = 1'b1;
          tx_word_d = bus.tx_data;
          err_d     = 1'b0;
          state_d   = bus.tx_req ? S_TX0 : S_RX0;
        end
      end
      S_TX0, S_TX1: begin
        stall_c   = 1'b1;
        wd_active = 1'b1;
        if (bus.tbr) begin
          iocs_c     = 1'b1;
          byte_sel_c = (state_q == S_TX0) ? HI_FIRST : !HI_FIRST;
          state_d    = (state_q == S_TX0) ? S_TX0_GAP : S_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RX0, S_RX1: begin
        stall_c   = 1'b1;
        wd_active = 1'b1;
        if (bus.rda) begin
          iocs_c = 1'b1;
          iorw_c = IORW_READ;
          // First RX byte lands in the half selected by HI_FIRST.
          if ((state_q == S_RX0) == HI_FIRST) begin
            rx_word_d[WORD_W-1:BYTE_W] = bus.rx_byte;
          end else begin
            rx_word_d[BYTE_W-1:0] = bus.rx_byte;
          end
          state_d = (state_q == S_RX0) ? S_RX0_GAP : S_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_TX0_GAP: begin
        stall_c = 1'b1;
        state_d = S_TX1;
      end
      S_RX0_GAP: begin
        stall_c = 1'b1;
        state_d = S_RX1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_word_q <= '0;
      rx_word_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_word_q <= tx_word_d;
      rx_word_q <= rx_word_d;
      err_q     <= err_d;
    end
  end

  // Reset forces stall low even if the pipeline still presents a request.
  assign bus.stall    = stall_c && rst_n;
  assign bus.iocs     = iocs_c;
  assign bus.iorw     = iorw_c;
  assign bus.byte_sel = byte_sel_c;
  assign bus.tx_word  = tx_word_q;
  assign bus.rx_word  = rx_word_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spart_word_ctrl.sv
// Bench for spart_word_ctrl: HI_FIRST=1 unit without watchdog, HI_FIRST=0 unit with TIMEOUT=8.
module tb_spart_word_ctrl;

  logic clk = 1'b0;
  logic rsta_n, rstb_n;
  always #5 clk = ~clk;

  spart_word_ctrl_if ifa ();
  spart_word_ctrl_if ifb ();

  spart_word_ctrl #(.HI_FIRST(1'b1), .TIMEOUT(16'd0)) dut_a (.clk(clk), .rst_n(rsta_n), .bus(ifa));
  spart_word_ctrl #(.HI_FIRST(1'b0), .TIMEOUT(16'd8)) dut_b (.clk(clk), .rst_n(rstb_n), .bus(ifb));

  int total = 0;
  int bad   = 0;

  typedef struct {logic rd; logic sel; logic chk_byte; logic [7:0] byt;} strobe_t;
  typedef struct {logic rd; logic [15:0] word; logic err;} done_t;
  typedef struct {logic tx; logic [15:0] data; logic [7:0] b0; logic [7:0] b1; int w;} vec_t;

  strobe_t strobe_q[$];
  done_t   done_q[$];
  vec_t    vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not observed within bound", name);
  endtask

  task automatic push_xfer(input logic tx, input logic [15:0] data, input logic [7:0] b0, input logic [7:0] b1);
    if (tx) begin
      strobe_q.push_back('{rd: 1'b0, sel: 1'b1, chk_byte: 1'b1, byt: data[15:8]});
      strobe_q.push_back('{rd: 1'b0, sel: 1'b0, chk_byte: 1'b1, byt: data[7:0]});
      done_q.push_back('{rd: 1'b0, word: data, err: 1'b0});
    end else begin
      strobe_q.push_back('{rd: 1'b1, sel: 1'b1, chk_byte: 1'b0, byt: 8'h00});
      strobe_q.push_back('{rd: 1'b1, sel: 1'b1, chk_byte: 1'b0, byt: 8'h00});
      done_q.push_back('{rd: 1'b1, word: {b0, b1}, err: 1'b0});
    end
  endtask

  // Scoreboard for unit A: every strobe and done pulse must match a queued expectation.
  always @(negedge clk) begin
    strobe_t s;
    done_t   d;
    if (rsta_n && ifa.iocs) begin
      if (strobe_q.size() == 0) begin
        fail_now("a_unexpected_strobe");
      end else begin
        s = strobe_q.pop_front();
        check("a_strobe_iorw", 32'(ifa.iorw), 32'(s.rd));
        check("a_strobe_sel", 32'(ifa.byte_sel), 32'(s.sel));
        if (s.chk_byte)
          check("a_strobe_byte", 32'(ifa.byte_sel ? ifa.tx_word[15:8] : ifa.tx_word[7:0]), 32'(s.byt));
      end
    end
    if (rsta_n && ifa.done) begin
      if (done_q.size() == 0) begin
        fail_now("a_unexpected_done");
      end else begin
        d = done_q.pop_front();
        check(d.rd ? "a_done_rx_word" : "a_done_tx_word", 32'(d.rd ? ifa.rx_word : ifa.tx_word), 32'(d.word));
        check("a_done_err", 32'(ifa.err), 32'(d.err));
      end
    end
  end

  // One transfer on unit A; flag goes low for w cycles before each byte, high in the gap cycle.
  task automatic run_a(input logic tx, input logic [15:0] data, input logic [7:0] b0, input logic [7:0] b1,
                       input int w, output int done_cyc, output int s0, output int s1,
                       output int nstr, output int stall_bad);
    logic flag, rearm, saw;
    int   lr;
    bit   hit;
    @(posedge clk); #1;
    push_xfer(tx, data, b0, b1);
    flag = 1'b1; rearm = (w > 0); lr = 0; saw = 1'b0; hit = 1'b0;
    nstr = 0; stall_bad = 0; s0 = -1; s1 = -1; done_cyc = -1;
    ifa.tx_data = data;
    ifa.rx_byte = b0;
    if (tx) ifa.tx_req = 1'b1; else ifa.rx_req = 1'b1;
    ifa.tbr = tx & flag;
    ifa.rda = !tx & flag;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      saw = ifa.iocs;
      if (saw) begin
        if (nstr == 0) s0 = cyc; else s1 = cyc;
        nstr++;
      end
      if (ifa.done) begin
        done_cyc = cyc;
        if (ifa.stall) stall_bad++;
        ifa.tx_req = 1'b0; ifa.rx_req = 1'b0; ifa.tbr = 1'b0; ifa.rda = 1'b0;
        hit = 1'b1;
        break;
      end
      if (!ifa.stall) stall_bad++;
      @(posedge clk); #1;
      if (saw) begin flag = 1'b1; rearm = (w > 0); end
      else if (rearm) begin rearm = 1'b0; lr = w - 1; flag = 1'b0; end
      else if (lr > 0) begin lr--; flag = 1'b0; end
      else flag = 1'b1;
      ifa.tbr = tx & flag;
      ifa.rda = !tx & flag;
      ifa.rx_byte = (nstr == 0) ? b0 : b1;
    end
    if (!hit) fail_now("a_xfer_timeout");
  endtask

  // One transfer on unit B with a constant flag level.
  task automatic run_b(input logic tx, input logic [15:0] data, input logic [7:0] b0, input logic [7:0] b1,
                       input logic flag, output int done_cyc, output int nstr, output logic [7:0] m0,
                       output logic [7:0] m1, output logic sel0, output logic err0, output logic err1,
                       output logic err_done);
    bit hit;
    @(posedge clk); #1;
    hit = 1'b0; done_cyc = -1; nstr = 0; m0 = 8'h00; m1 = 8'h00; sel0 = 1'bx;
    err0 = 1'bx; err1 = 1'bx; err_done = 1'bx;
    ifb.tx_data = data; ifb.rx_byte = b0;
    if (tx) ifb.tx_req = 1'b1; else ifb.rx_req = 1'b1;
    ifb.tbr = tx & flag;
    ifb.rda = !tx & flag;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 0) err0 = ifb.err;
      if (cyc == 1) err1 = ifb.err;
      if (ifb.iocs) begin
        if (nstr == 0) begin
          m0 = ifb.byte_sel ? ifb.tx_word[15:8] : ifb.tx_word[7:0];
          sel0 = ifb.byte_sel;
        end else begin
          m1 = ifb.byte_sel ? ifb.tx_word[15:8] : ifb.tx_word[7:0];
        end
        nstr++;
      end
      if (ifb.done) begin
        done_cyc = cyc; err_done = ifb.err;
        ifb.tx_req = 1'b0; ifb.rx_req = 1'b0; ifb.tbr = 1'b0; ifb.rda = 1'b0;
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
      ifb.rx_byte = (nstr == 0) ? b0 : b1;
    end
    if (!hit) fail_now("b_xfer_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int dc, s0, s1, ns, sb, d1, d2, nrd, nd, cnt;
    logic [7:0] m0, m1;
    logic sel0, e0, e1, ed;

    vecs[0] = '{tx: 1'b1, data: 16'hA55A, b0: 8'h00, b1: 8'h00, w: 0};
    vecs[1] = '{tx: 1'b0, data: 16'h0000, b0: 8'h12, b1: 8'h34, w: 0};
    vecs[2] = '{tx: 1'b1, data: 16'h0001, b0: 8'h00, b1: 8'h00, w: 0};
    vecs[3] = '{tx: 1'b1, data: 16'hC3E7, b0: 8'h00, b1: 8'h00, w: 10};
    vecs[4] = '{tx: 1'b0, data: 16'h0000, b0: 8'h80, b1: 8'h7F, w: 3};
    vecs[5] = '{tx: 1'b0, data: 16'h0000, b0: 8'h00, b1: 8'hFF, w: 0};

    {ifa.tx_req, ifa.rx_req, ifa.tbr, ifa.rda} = 4'b0;
    {ifb.tx_req, ifb.rx_req, ifb.tbr, ifb.rda} = 4'b0;
    ifa.tx_data = 16'h0; ifa.rx_byte = 8'h0; ifb.tx_data = 16'h0; ifb.rx_byte = 8'h0;
    rsta_n = 1'b1; rstb_n = 1'b1;
    #1; rsta_n = 1'b0; rstb_n = 1'b0;
    #12;
    check("rst_stall", 32'(ifa.stall), 32'd0);
    check("rst_iocs_iorw_done_err", 32'({ifa.iocs, ifa.iorw, ifa.done, ifa.err}), 32'd0);
    check("rst_words", 32'({ifa.tx_word, ifa.rx_word}), 32'd0);
    check("rst_byte_sel_a", 32'(ifa.byte_sel), 32'd1);
    check("rst_byte_sel_b", 32'(ifb.byte_sel), 32'd0);
    @(posedge clk); #1;
    rsta_n = 1'b1; rstb_n = 1'b1;

    // Table-driven transfers on unit A.
    foreach (vecs[i]) begin
      run_a(vecs[i].tx, vecs[i].data, vecs[i].b0, vecs[i].b1, vecs[i].w, dc, s0, s1, ns, sb);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(4 + 2 * vecs[i].w));
      check($sformatf("v%0d_strobe0_cycle", i), 32'(s0), 32'(1 + vecs[i].w));
      check($sformatf("v%0d_strobe1_cycle", i), 32'(s1), 32'(3 + 2 * vecs[i].w));
      check($sformatf("v%0d_strobe_count", i), 32'(ns), 32'd2);
      check($sformatf("v%0d_stall_profile", i), 32'(sb), 32'd0);
    end

    // TX and RX together: TX first, RX accepted in the IDLE cycle after done.
    @(posedge clk); #1;
    push_xfer(1'b1, 16'h1357, 8'h00, 8'h00);
    push_xfer(1'b0, 16'h0000, 8'hAB, 8'hCD);
    ifa.tx_data = 16'h1357; ifa.rx_byte = 8'hAB;
    ifa.tx_req = 1'b1; ifa.rx_req = 1'b1; ifa.tbr = 1'b1; ifa.rda = 1'b1;
    nrd = 0; nd = 0; d1 = -1; d2 = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (ifa.iocs && ifa.iorw) nrd++;
      if (ifa.done) begin
        nd++;
        if (nd == 1) begin d1 = cyc; ifa.tx_req = 1'b0; end
        else begin d2 = cyc; ifa.rx_req = 1'b0; break; end
      end
      @(posedge clk); #1;
      ifa.rx_byte = (nrd == 0) ? 8'hAB : 8'hCD;
    end
    ifa.tbr = 1'b0; ifa.rda = 1'b0;
    check("both_tx_done_cycle", 32'(d1), 32'd4);
    check("both_rx_done_cycle", 32'(d2), 32'd9);

    // Reset while waiting in TX1: second byte must never go out.
    @(posedge clk); #1;
    strobe_q.push_back('{rd: 1'b0, sel: 1'b1, chk_byte: 1'b1, byt: 8'hBE});
    ifa.tx_data = 16'hBEEF; ifa.tx_req = 1'b1; ifa.tbr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; ifa.tbr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst6_pre_stall_iocs", 32'({ifa.stall, ifa.iocs}), 32'b10);
    @(posedge clk); #1;
    rsta_n = 1'b0;
    #1;
    check("rst6_stall_iocs_done", 32'({ifa.stall, ifa.iocs, ifa.done}), 32'd0);
    check("rst6_tx_word", 32'(ifa.tx_word), 32'd0);
    ifa.tx_req = 1'b0;
    @(posedge clk); #1;
    rsta_n = 1'b1; ifa.tbr = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.iocs || ifa.stall) cnt++;
    end
    check("rst6_quiet_after_release", 32'(cnt), 32'd0);
    ifa.tbr = 1'b0;

    // Unit B: RX watchdog abort, sticky err, then err cleared on next acceptance.
    run_b(1'b0, 16'h0, 8'h00, 8'h00, 1'b0, dc, ns, m0, m1, sel0, e0, e1, ed);
    check("b_rx_timeout_done_cycle", 32'(dc), 32'd9);
    check("b_rx_timeout_strobes", 32'(ns), 32'd0);
    check("b_rx_timeout_err", 32'(ed), 32'd1);
    check("b_rx_timeout_rx_word", 32'(ifb.rx_word), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_err_sticky", 32'(ifb.err), 32'd1);

    run_b(1'b0, 16'h0, 8'h12, 8'h34, 1'b1, dc, ns, m0, m1, sel0, e0, e1, ed);
    check("b_rx_err_at_accept", 32'(e0), 32'd1);
    check("b_rx_err_cleared", 32'(e1), 32'd0);
    check("b_rx_done_cycle", 32'(dc), 32'd4);
    check("b_rx_strobes", 32'(ns), 32'd2);
    check("b_rx_word_lo_first", 32'(ifb.rx_word), 32'h3412);
    check("b_rx_byte_sel", 32'(sel0), 32'd0);
    check("b_rx_err_done", 32'(ed), 32'd0);

    run_b(1'b1, 16'h1111, 8'h00, 8'h00, 1'b0, dc, ns, m0, m1, sel0, e0, e1, ed);
    check("b_tx_timeout_done_cycle", 32'(dc), 32'd9);
    check("b_tx_timeout_strobes", 32'(ns), 32'd0);
    check("b_tx_timeout_err", 32'(ed), 32'd1);

    run_b(1'b1, 16'hA55A, 8'h00, 8'h00, 1'b1, dc, ns, m0, m1, sel0, e0, e1, ed);
    check("b_tx_done_cycle", 32'(dc), 32'd4);
    check("b_tx_first_byte", 32'(m0), 32'h5A);
    check("b_tx_second_byte", 32'(m1), 32'hA5);
    check("b_tx_err_cleared", 32'(ed), 32'd0);

    repeat (2) @(posedge clk);
    check("a_strobe_queue_drained", 32'(strobe_q.size()), 32'd0);
    check("a_done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
